// File: rtl/jtframe_scan2x_sync_pkg.sv
// Shared video helpers for the scan-doubler sync block: counter sizing and
// the VS re-timing state encoding.
package jtframe_scan2x_sync_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_SYNC = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    // Horizontal counter width for a given maximum line length
    function automatic int calc_aw(input int hlen);
        return (hlen <= 512) ? 9 : 10;
    endfunction

endpackage

// File: rtl/jtframe_edge.sv
// Registered rise/fall detector. The previous level is captured on cen only,
// and the edge flags are qualified by cen so they are one clk wide.
module jtframe_edge (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic last;

    // remember the level seen at the previous enable
    always_ff @(posedge clk) begin
        if (rst)      last <= 1'b0;
        else if (cen) last <= din;
    end

    assign rise = cen &  din & ~last;
    assign fall = cen & ~din &  last;

endmodule

// File: rtl/jtframe_scan2x_sync.sv
// Scan-doubler output timing: measures the original line (length, blanking
// window), builds DE on the doubled side, re-times VS onto x2_HS and
// registers all VGA outputs with a single clk of latency.
module jtframe_scan2x_sync
    import jtframe_scan2x_sync_pkg::*;
#(
    parameter int COLORW = 4,
    parameter int HLEN   = 512,
    parameter int BLANK  = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pxl_cen,
    input  logic                  pxl2_cen,
    input  logic                  HS,
    input  logic                  VS,
    input  logic                  LHBL,
    input  logic                  LVBL,
    input  logic [3*COLORW-1:0]   x2_pxl,
    input  logic                  x2_HS,
    output logic [3*COLORW-1:0]   vga_pxl,
    output logic                  vga_HS,
    output logic                  vga_VS,
    output logic                  vga_DE,
    output logic                  locked
);

    localparam int   AW   = calc_aw(HLEN);
    localparam logic PASS = (BLANK == 0);

    logic hs_rise, hs_fall, vs_rise, vs_fall;
    logic hb_rise, hb_fall, x2hs_rise, x2hs_fall;
    logic unused_edges;

    jtframe_edge u_hs   (.clk(clk), .rst(rst), .cen(pxl_cen),  .din(HS),    .rise(hs_rise),   .fall(hs_fall));
    jtframe_edge u_vs   (.clk(clk), .rst(rst), .cen(pxl_cen),  .din(VS),    .rise(vs_rise),   .fall(vs_fall));
    jtframe_edge u_hb   (.clk(clk), .rst(rst), .cen(pxl_cen),  .din(LHBL),  .rise(hb_rise),   .fall(hb_fall));
    jtframe_edge u_x2hs (.clk(clk), .rst(rst), .cen(pxl2_cen), .din(x2_HS), .rise(x2hs_rise), .fall(x2hs_fall));

    assign unused_edges = hs_fall | x2hs_fall;

    logic [AW-1:0] hcnt1, hcnt1_nx, len1;
    logic [AW:0]   hb_end, hb_start, hpos2, hcnt2;
    logic [1:0]    vb_dly;
    logic          h_act, v_act, de_src;

    // hcnt1_nx is the index of the pixel being sampled now, so blanking
    // edges and line length are taken from the pre-clear count
    assign hcnt1_nx = hcnt1 + 1'b1;
    assign hpos2    = {hcnt1_nx, 1'b0};

    // original-side line measurement, blanking window and line lock
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt1    <= '0;
            len1     <= '0;
            locked   <= 1'b0;
            vb_dly   <= '0;
            hb_end   <= '0;
            hb_start <= '1;
        end else if (pxl_cen) begin
            if (hb_rise) hb_end   <= hpos2;
            if (hb_fall) hb_start <= hpos2;
            if (hs_rise) begin
                hcnt1  <= '0;
                len1   <= hcnt1_nx;
                locked <= (hcnt1_nx == len1) && (hcnt1_nx != '0);
                vb_dly <= {vb_dly[0], LVBL};
            end else begin
                hcnt1 <= hcnt1_nx;
                if (&hcnt1) locked <= 1'b0;
            end
        end
    end

    // doubled-side position, saturating so a missing x2_HS cannot wrap DE
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt2 <= '0;
        end else if (pxl2_cen) begin
            if (x2hs_rise)    hcnt2 <= '0;
            else if (~&hcnt2) hcnt2 <= hcnt2 + 1'b1;
        end
    end

    assign h_act  = (hb_start > hb_end) && (hcnt2 >= hb_end) && (hcnt2 < hb_start);
    assign v_act  = vb_dly[1];
    assign de_src = h_act & v_act;

    // output stage, every clk so all outputs share one clk of latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_pxl <= '0;
            vga_HS  <= 1'b0;
            vga_DE  <= 1'b0;
        end else begin
            vga_pxl <= (de_src || PASS) ? x2_pxl : '0;
            vga_HS  <= x2_HS;
            vga_DE  <= de_src;
        end
    end

    logic [1:0] st;
    logic       rearm;

    // VS re-timing: vga_VS only changes on x2_HS rising edges; a new VS
    // arriving while releasing forces at least one low line before re-arming
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            rearm  <= 1'b0;
            vga_VS <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: if (vs_rise) st <= ST_ARM;
                ST_ARM: if (x2hs_rise) begin
                    st     <= ST_SYNC;
                    vga_VS <= 1'b1;
                end
                ST_SYNC: if (vs_fall) st <= ST_REL;
                ST_REL: begin
                    if (x2hs_rise) begin
                        vga_VS <= 1'b0;
                        rearm  <= 1'b0;
                        st     <= (rearm || vs_rise) ? ST_ARM : ST_IDLE;
                    end else if (vs_rise) begin
                        rearm <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_scan2x_sync.sv
// Bench: two DUTs (BLANK=1 and BLANK=0) on shared stimulus. Lines are planned
// up front (length, LVBL, VS pulses); expected outputs come from per-line
// rules over that plan.
module tb_jtframe_scan2x_sync;

    localparam int NL = 28;
    localparam int NX = NL + 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        pxl_cen = 1'b0, pxl2_cen = 1'b0;
    logic        HS = 1'b0, VS = 1'b0, LHBL = 1'b0, LVBL = 1'b0, x2_HS = 1'b0;
    logic [11:0] x2_pxl = '0;
    logic [11:0] pxl_b1, pxl_b0;
    logic        hs_b1, vs_b1, de_b1, lk_b1, hs_b0, vs_b0, de_b0, lk_b0;

    always #5 clk = ~clk;

    jtframe_scan2x_sync #(.COLORW(4), .HLEN(512), .BLANK(1)) u1 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen),
        .HS(HS), .VS(VS), .LHBL(LHBL), .LVBL(LVBL), .x2_pxl(x2_pxl), .x2_HS(x2_HS),
        .vga_pxl(pxl_b1), .vga_HS(hs_b1), .vga_VS(vs_b1), .vga_DE(de_b1), .locked(lk_b1));

    jtframe_scan2x_sync #(.COLORW(4), .HLEN(512), .BLANK(0)) u0 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .pxl2_cen(pxl2_cen),
        .HS(HS), .VS(VS), .LHBL(LHBL), .LVBL(LVBL), .x2_pxl(x2_pxl), .x2_HS(x2_HS),
        .vga_pxl(pxl_b0), .vga_HS(hs_b0), .vga_VS(vs_b0), .vga_DE(de_b0), .locked(lk_b0));

    int checks = 0, errors = 0;
    int len [0:NX-1];
    bit lvbl[0:NX-1];
    int pr_line[0:4], pr_pix[0:4], pf_line[0:4], pf_pix[0:4];
    int de_cnt[0:NX-1];
    bit vs_at[0:NX-1], lk_at[0:NX-1];
    int first_vs_n = -1, first_vs_q = -1;

    bit          chk_en = 1'b0, e_de, e_hs, e_vs, e_lk, prev_act;
    logic [11:0] e_pxl1, e_pxl0;
    int          e_src = -1, e_n = 0, e_q = 0, prev_src = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (line %0d q %0d)", nm, act, exp, e_n, e_q);
        end
    endtask

    function automatic int pos(input int n, input int p);
        return n * 1000 + p;
    endfunction

    function automatic bit vs_level(input int n, input int p);
        for (int i = 0; i < 5; i++)
            if (pos(n, p) >= pos(pr_line[i], pr_pix[i]) && pos(n, p) < pos(pf_line[i], pf_pix[i]))
                return 1'b1;
        return 1'b0;
    endfunction

    // DE source for x2 position q of line n: window [2*blank pixels, 2*previous length)
    function automatic bit act_m(input int n, input int q);
        int hbe, hbs;
        bit v;
        v   = (n >= 1) ? lvbl[n-1] : 1'b0;
        hbe = (n == 0 && q < 128) ? 0 : 128;
        hbs = (n == 0) ? 1023 : 2 * len[n-1];
        return v && (q >= hbe) && (q < hbs);
    endfunction

    // vga_VS over line n: high from the line after the rise to the line of
    // the fall; a rise in the same line as the previous fall costs one line
    function automatic bit vs_m(input int n);
        int s;
        for (int i = 0; i < 3; i++) begin
            s = pr_line[i] + 1;
            if (i > 0 && pr_line[i] == pf_line[i-1]) s++;
            if (n >= s && n <= pf_line[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit lk_m(input int n);
        return (n >= 2) && (len[n-1] == len[n-2]);
    endfunction

    task automatic drive_line(input int n, input int qmax, input bit chk_on);
        int p;
        bit a;
        for (int q = 0; q < qmax; q++) begin
            @(negedge clk);
            p        = q / 2;
            pxl_cen  = (q % 2 == 0);
            pxl2_cen = 1'b1;
            HS       = (p < 32);
            LHBL     = (p >= 64);
            LVBL     = lvbl[n];
            VS       = vs_level(n, p);
            x2_HS    = (q < 64);
            x2_pxl   = (n >= 20) ? 12'hFFF : 12'($urandom);
            a        = act_m(n, q);
            e_de     = prev_act;
            e_src    = prev_src;
            e_pxl1   = prev_act ? x2_pxl : 12'h000;
            e_pxl0   = x2_pxl;
            e_hs     = x2_HS;
            e_vs     = vs_m(n);
            e_lk     = lk_m(n);
            e_n      = n;
            e_q      = q;
            chk_en   = chk_on;
            prev_act = a;
            prev_src = n;
        end
    endtask

    // per-cycle comparison against the planned-line model
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("de",      de_b1,  e_de);
            chk("pxl_b1",  pxl_b1, e_pxl1);
            chk("hs",      hs_b1,  e_hs);
            chk("vs",      vs_b1,  e_vs);
            chk("locked",  lk_b1,  e_lk);
            chk("de_b0",   de_b0,  e_de);
            chk("pxl_b0",  pxl_b0, e_pxl0);
            chk("hs_b0",   hs_b0,  e_hs);
            chk("vs_b0",   vs_b0,  e_vs);
            chk("lk_b0",   lk_b0,  e_lk);
            if (e_src >= 0 && de_b1) de_cnt[e_src]++;
            if (e_q == 5) begin
                vs_at[e_n] = vs_b1;
                lk_at[e_n] = lk_b1;
            end
            if (vs_b1 && first_vs_n < 0) begin
                first_vs_n = e_n;
                first_vs_q = e_q;
            end
        end
    end

    initial begin
        for (int n = 0; n < NX; n++) begin
            len[n]    = (n >= 12) ? 385 : 384;
            lvbl[n]   = (n < 4) ? 1'b0 : ($urandom_range(3, 0) != 0);
            de_cnt[n] = 0;
        end
        lvbl[4] = 1'b1; lvbl[11] = 1'b1; lvbl[12] = 1'b1;
        for (int n = NL; n < NX; n++) lvbl[n] = 1'b1;
        len[NX-2] = 384; len[NX-1] = 384;
        pr_line[0] = 6;  pr_pix[0] = $urandom_range(380, 1);
        pf_line[0] = 8;  pf_pix[0] = $urandom_range(150, 1);
        pr_line[1] = 8;  pr_pix[1] = $urandom_range(380, 200);
        pf_line[1] = 10; pf_pix[1] = $urandom_range(380, 1);
        pr_line[2] = 16 + $urandom_range(2, 0); pr_pix[2] = $urandom_range(380, 1);
        pf_line[2] = pr_line[2] + 1 + $urandom_range(1, 0); pf_pix[2] = $urandom_range(380, 1);
        pr_line[3] = NL;     pr_pix[3] = 100;
        pf_line[3] = NL + 1; pf_pix[3] = 300;
        pr_line[4] = NL + 2; pr_pix[4] = 100;
        pf_line[4] = NL + 2; pf_pix[4] = 200;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pxl_b1", pxl_b1, 0); chk("rst_pxl_b0", pxl_b0, 0);
        chk("rst_hs", hs_b1, 0); chk("rst_vs", vs_b1, 0);
        chk("rst_de", de_b1, 0); chk("rst_locked", lk_b1, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_act = 1'b0;
        prev_src = -1;

        for (int n = 0; n < NL; n++) drive_line(n, 2 * len[n], 1'b1);
        @(negedge clk);
        chk_en = 1'b0;

        chk("de_cnt_vblank", de_cnt[3], 0);
        chk("de_cnt_384", de_cnt[5], 640);
        chk("de_cnt_first385", de_cnt[12], 640);
        chk("de_cnt_385", de_cnt[13], 642);
        chk("lk_line1", lk_at[1], 0);
        chk("lk_line2", lk_at[2], 1);
        chk("lk_line12", lk_at[12], 1);
        chk("lk_line13", lk_at[13], 0);
        chk("lk_line14", lk_at[14], 1);
        chk("vs_line6", vs_at[6], 0);
        chk("vs_line7", vs_at[7], 1);
        chk("vs_line9_rel", vs_at[9], 0);
        chk("vs_line10", vs_at[10], 1);
        chk("vs_line11", vs_at[11], 0);
        chk("vs_first_line", first_vs_n, 7);
        chk("vs_first_q", first_vs_q, 0);

        // reset while vga_VS is asserted
        drive_line(NL, 2 * len[NL], 1'b0);
        drive_line(NL + 1, 200, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_vs", vs_b1, 1);
        chk("pre_rst_locked", lk_b1, 1);
        @(negedge clk);
        rst = 1'b1; pxl_cen = 1'b0; pxl2_cen = 1'b0;
        VS = 1'b0; HS = 1'b0; LHBL = 1'b0; x2_HS = 1'b0; x2_pxl = 12'hFFF;
        @(posedge clk);
        #1;
        chk("mid_rst_vs", vs_b1, 0);
        chk("mid_rst_locked", lk_b1, 0);
        chk("mid_rst_de", de_b1, 0);
        chk("mid_rst_hs", hs_b1, 0);
        chk("mid_rst_pxl_b1", pxl_b1, 0);
        chk("mid_rst_pxl_b0", pxl_b0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive_line(NL + 2, 2 * len[NL+2], 1'b0);
        drive_line(NL + 3, 100, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_vs_armed", vs_b1, 1);
        chk("post_rst_locked", lk_b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
